// File: rtl/fetch_sequencer_pkg.sv
// Shared constants and state encoding for the instruction fetch front end.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fetch_sequencer_pkg;

    localparam int          ADDR_DEFAULT     = 32;
    localparam int          WORD_DEFAULT     = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Byte distance between consecutive instruction words.
    localparam int          PC_INC           = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/fetch_resp_buffer.sv
// Small FIFO of {pc, inst} pairs with synchronous clear; head is shown combinationally.
// Latency: a push is visible at the head on the cycle after it is written.
// Backpressure: pushes when full and pops when empty are ignored; clear wins over push/pop.
// Ports: clk, reset (async, active-high), push/push_pc/push_inst, pop, clear,
//        head_pc/head_inst (oldest entry), count (occupancy), empty.
module fetch_resp_buffer
    import fetch_sequencer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [AW-1:0]            push_pc,
    input  logic [DW-1:0]            push_inst,
    input  logic                     pop,
    input  logic                     clear,
    output logic [AW-1:0]            head_pc,
    output logic [DW-1:0]            head_inst,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] pc_mem   [DEPTH];
    logic [DW-1:0] inst_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign do_push = push & (count != (PW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            pc_mem[wr_ptr]   <= push_pc;
            inst_mem[wr_ptr] <= push_inst;
        end
    end

    assign head_pc   = pc_mem[rd_ptr];
    assign head_inst = inst_mem[rd_ptr];

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch front end: owns the PC, issues credit-limited imem requests, buffers and delivers words.
// Latency: issue in cycle N, response in N+1, v_o in N+2 at the earliest.
// Backpressure: stall_i holds the buffer head; new requests stop once in-flight + buffered hit CREDITS.
// Ports: clk/reset; imem_req_o/imem_addr_o/imem_gnt_i request side; imem_rvalid_i/imem_rdata_i
//        in-order responses; v_o/inst_o/pc_o/stall_i to the queue; branch_i/branch_pc_i redirect
//        with flush_o to the queue; halt_i stops issue; busy_o when anything is in flight or held.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int              ADDR     = ADDR_DEFAULT,
    parameter int              WORD     = WORD_DEFAULT,
    parameter logic [ADDR-1:0] RESET_PC = ADDR'(RESET_PC_DEFAULT),
    parameter int              CREDITS  = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_o,
    output logic [ADDR-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [WORD-1:0] imem_rdata_i,
    output logic            v_o,
    output logic [WORD-1:0] inst_o,
    output logic [ADDR-1:0] pc_o,
    input  logic            stall_i,
    input  logic            branch_i,
    input  logic [ADDR-1:0] branch_pc_i,
    output logic            flush_o,
    input  logic            halt_i,
    output logic            busy_o
);

    localparam int CW = $clog2(CREDITS) + 1;

    state_t          state;
    state_t          state_next;
    logic [ADDR-1:0] pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   drop_load;
    logic [CW:0]     credits_used;
    logic            branch_act;
    logic            issue;
    logic            resp_drop;
    logic            resp_in;
    logic            resp_take;

    logic [CW-1:0]   buf_count;
    logic            buf_empty;
    logic [ADDR-1:0] buf_pc;
    logic [WORD-1:0] buf_inst;
    logic [ADDR-1:0] tag_pc;
    logic [0:0]      tag_inst_unused;
    logic [CW-1:0]   tag_count_unused;
    logic            tag_empty_unused;

    assign branch_act   = branch_i & (state != IDLE);
    assign credits_used = {1'b0, outstanding} + {1'b0, buf_count};

    assign imem_req_o  = (state == RUN) & ~halt_i & ~branch_i &
                         (credits_used < (CW+1)'(CREDITS));
    assign imem_addr_o = pc;
    assign issue       = imem_req_o & imem_gnt_i;

    // A response is either owed to a pre-branch request (drop) or completes a live request.
    // rvalid with nothing in flight is ignored.
    assign resp_drop = imem_rvalid_i & (drop != '0);
    assign resp_in   = imem_rvalid_i & (drop == '0) & (outstanding != '0);
    assign resp_take = resp_in & ~branch_act;

    // Requests still in flight once this cycle settles; all of them become stale on a branch.
    assign drop_load = outstanding + CW'(issue) - CW'(resp_in);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = RUN;
            RUN:     if (branch_i && drop_load != '0) state_next = FLUSH;
            FLUSH:   if (!branch_i && (drop - CW'(resp_drop)) == '0) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            state <= state_next;

            if (branch_act)  pc <= branch_pc_i;
            else if (issue)  pc <= pc + ADDR'(PC_INC);

            if (branch_act) outstanding <= '0;
            else            outstanding <= outstanding + CW'(issue) - CW'(resp_take);

            // A second branch while flushing only retargets the PC; the stale count keeps draining.
            if (branch_act && state == RUN) drop <= drop_load;
            else if (resp_drop)             drop <= drop - CW'(1);
        end
    end

    fetch_resp_buffer #(
        .DEPTH (CREDITS),
        .AW    (ADDR),
        .DW    (1)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (issue),
        .push_pc   (pc),
        .push_inst (1'b0),
        .pop       (resp_take),
        .clear     (branch_act),
        .head_pc   (tag_pc),
        .head_inst (tag_inst_unused),
        .count     (tag_count_unused),
        .empty     (tag_empty_unused)
    );

    fetch_resp_buffer #(
        .DEPTH (CREDITS),
        .AW    (ADDR),
        .DW    (WORD)
    ) u_resp_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (resp_take),
        .push_pc   (tag_pc),
        .push_inst (imem_rdata_i),
        .pop       (~stall_i),
        .clear     (branch_act),
        .head_pc   (buf_pc),
        .head_inst (buf_inst),
        .count     (buf_count),
        .empty     (buf_empty)
    );

    // Head data is forced to zero when nothing is valid so idle outputs are deterministic.
    assign v_o     = ~buf_empty;
    assign inst_o  = buf_empty ? '0 : buf_inst;
    assign pc_o    = buf_empty ? '0 : buf_pc;
    assign flush_o = branch_act;
    assign busy_o  = (outstanding | drop | buf_count) != '0;

`ifndef SYNTHESIS
    rvalid_needs_inflight: assert property (@(posedge clk) disable iff (reset)
        imem_rvalid_i |-> (outstanding != '0 || drop != '0));
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i  = 32'h0;
    logic        v_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        stall_i;
    logic        branch_i;
    logic [31:0] branch_pc_i;
    logic        flush_o;
    logic        halt_i;
    logic        busy_o;

    logic        mem_hold;
    logic [31:0] pend [$];
    int          n_tests;
    int          n_fail;

    fetch_sequencer #(.CREDITS(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .v_o           (v_o),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .stall_i       (stall_i),
        .branch_i      (branch_i),
        .branch_pc_i   (branch_pc_i),
        .flush_o       (flush_o),
        .halt_i        (halt_i),
        .busy_o        (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // In-order memory: one-cycle latency, data = 0x1000_0000 + addr; mem_hold defers replies.
    always @(posedge clk) begin
        if (reset) begin
            pend.delete();
            #1;
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'h0;
        end else begin
            if (imem_req_o && imem_gnt_i) pend.push_back(imem_addr_o);
            #1;
            if (!mem_hold && pend.size() != 0) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = 32'h1000_0000 + pend.pop_front();
            end else begin
                imem_rvalid_i = 1'b0;
                imem_rdata_i  = 32'h0;
            end
        end
    end

    // Leaves the bench at the negedge where reset drops (the IDLE cycle, "c0").
    task automatic do_reset(input logic gnt);
        @(negedge clk);
        reset = 1'b1; imem_gnt_i = gnt; stall_i = 1'b0; branch_i = 1'b0;
        branch_pc_i = 32'h0; halt_i = 1'b0; mem_hold = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; imem_gnt_i = 1'b1; stall_i = 1'b0; halt_i = 1'b0; mem_hold = 1'b0;
        branch_i = 1'b1; branch_pc_i = 32'h300;
        @(negedge clk); #1;
        n_tests++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req_o); end
        n_tests++; if (imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", imem_addr_o); end
        n_tests++; if (v_o !== 1'b0) begin n_fail++; $display("FAIL reset_v: got %b want 0", v_o); end
        n_tests++; if (inst_o !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h want 0", inst_o); end
        n_tests++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", pc_o); end
        n_tests++; if (flush_o !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b want 0", flush_o); end
        n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        branch_i = 1'b0;
    endtask

    task automatic test_stream;
        do_reset(1'b1); #1;
        n_tests++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL stream_idle_req: got %b want 0", imem_req_o); end
        @(negedge clk); #1; // c1
        n_tests++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL stream_c1: req %b addr %h want 1/0", imem_req_o, imem_addr_o); end
        n_tests++; if (v_o !== 1'b0) begin n_fail++; $display("FAIL stream_c1_v: got %b want 0", v_o); end
        @(negedge clk); #1; // c2
        n_tests++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin n_fail++; $display("FAIL stream_c2: req %b addr %h want 1/4", imem_req_o, imem_addr_o); end
        n_tests++; if (v_o !== 1'b0 || busy_o !== 1'b1) begin n_fail++; $display("FAIL stream_c2_v_busy: v %b busy %b want 0/1", v_o, busy_o); end
        @(negedge clk); #1; // c3: first word, two cycles after first grant
        n_tests++; if (v_o !== 1'b1 || pc_o !== 32'h0 || inst_o !== 32'h1000_0000) begin n_fail++; $display("FAIL stream_first: v %b pc %h inst %h want 1/0/10000000", v_o, pc_o, inst_o); end
        n_tests++; if (imem_addr_o !== 32'h8) begin n_fail++; $display("FAIL stream_c3_addr: got %h want 8", imem_addr_o); end
        for (int k = 4; k <= 8; k++) begin
            @(negedge clk); #1;
            n_tests++;
            if (v_o !== 1'b1 || pc_o !== 32'(4*(k-3)) || inst_o !== 32'h1000_0000 + 32'(4*(k-3)) || imem_addr_o !== 32'(4*(k-1))) begin
                n_fail++; $display("FAIL stream_c%0d: v %b pc %h inst %h addr %h want 1/%h/%h/%h", k, v_o, pc_o, inst_o, imem_addr_o, 4*(k-3), 32'h1000_0000 + 32'(4*(k-3)), 4*(k-1));
            end
        end
    endtask

    task automatic test_stall;
        logic [31:0] exp_pc;
        int          got;
        do_reset(1'b1);
        repeat (4) @(negedge clk);
        @(negedge clk); stall_i = 1'b1; #1; // c5
        n_tests++; if (v_o !== 1'b1 || pc_o !== 32'h8) begin n_fail++; $display("FAIL stall_c5: v %b pc %h want 1/8", v_o, pc_o); end
        for (int k = 6; k <= 9; k++) begin
            @(negedge clk); #1;
            n_tests++; if (v_o !== 1'b1 || pc_o !== 32'h8) begin n_fail++; $display("FAIL stall_hold_c%0d: v %b pc %h want 1/8", k, v_o, pc_o); end
            if (k >= 8) begin
                n_tests++; if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h18) begin n_fail++; $display("FAIL stall_credit_c%0d: req %b addr %h want 0/18", k, imem_req_o, imem_addr_o); end
            end
        end
        @(negedge clk); stall_i = 1'b0;
        exp_pc = 32'h8; got = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (v_o === 1'b1) begin
                n_tests++; if (pc_o !== exp_pc || inst_o !== exp_pc + 32'h1000_0000) begin n_fail++; $display("FAIL stall_order: pc %h inst %h want %h/%h", pc_o, inst_o, exp_pc, exp_pc + 32'h1000_0000); end
                exp_pc = exp_pc + 32'h4; got++;
            end
            @(negedge clk);
        end
        n_tests++; if (got !== 12) begin n_fail++; $display("FAIL stall_resume_count: got %0d want 12", got); end
    endtask

    task automatic test_branch_outstanding;
        do_reset(1'b1);
        @(negedge clk); mem_hold = 1'b1; // c1
        @(negedge clk);                  // c2
        @(negedge clk); branch_i = 1'b1; branch_pc_i = 32'h200; #1; // c3: two outstanding
        n_tests++; if (flush_o !== 1'b1 || imem_req_o !== 1'b0) begin n_fail++; $display("FAIL br_pulse: flush %b req %b want 1/0", flush_o, imem_req_o); end
        @(negedge clk); branch_i = 1'b0; mem_hold = 1'b0; #1; // c4
        n_tests++; if (flush_o !== 1'b0 || imem_req_o !== 1'b0 || imem_addr_o !== 32'h200) begin n_fail++; $display("FAIL br_c4: flush %b req %b addr %h want 0/0/200", flush_o, imem_req_o, imem_addr_o); end
        n_tests++; if (v_o !== 1'b0 || busy_o !== 1'b1) begin n_fail++; $display("FAIL br_c4_v_busy: v %b busy %b want 0/1", v_o, busy_o); end
        for (int k = 5; k <= 6; k++) begin
            @(negedge clk); #1;
            n_tests++; if (imem_req_o !== 1'b0 || v_o !== 1'b0) begin n_fail++; $display("FAIL br_flush_c%0d: req %b v %b want 0/0", k, imem_req_o, v_o); end
        end
        @(negedge clk); #1; // c7
        n_tests++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200 || busy_o !== 1'b0 || v_o !== 1'b0) begin n_fail++; $display("FAIL br_c7: req %b addr %h busy %b v %b want 1/200/0/0", imem_req_o, imem_addr_o, busy_o, v_o); end
        @(negedge clk); #1; // c8
        n_tests++; if (v_o !== 1'b0 || imem_addr_o !== 32'h204) begin n_fail++; $display("FAIL br_c8: v %b addr %h want 0/204", v_o, imem_addr_o); end
        @(negedge clk); #1; // c9
        n_tests++; if (v_o !== 1'b1 || pc_o !== 32'h200 || inst_o !== 32'h1000_0200) begin n_fail++; $display("FAIL br_first: v %b pc %h inst %h want 1/200/10000200", v_o, pc_o, inst_o); end
    endtask

    task automatic test_branch_coincident;
        do_reset(1'b1);
        @(negedge clk); mem_hold = 1'b1; // c1
        @(negedge clk);                  // c2
        @(negedge clk); mem_hold = 1'b0; // c3
        @(negedge clk); branch_i = 1'b1; branch_pc_i = 32'h400; #1; // c4: grant high, rvalid arriving
        n_tests++; if (flush_o !== 1'b1 || imem_req_o !== 1'b0 || busy_o !== 1'b1) begin n_fail++; $display("FAIL co_c4: flush %b req %b busy %b want 1/0/1", flush_o, imem_req_o, busy_o); end
        @(negedge clk); branch_i = 1'b0; #1; // c5
        n_tests++; if (v_o !== 1'b0 || imem_req_o !== 1'b0 || busy_o !== 1'b1) begin n_fail++; $display("FAIL co_c5: v %b req %b busy %b want 0/0/1", v_o, imem_req_o, busy_o); end
        @(negedge clk); #1; // c6
        n_tests++; if (v_o !== 1'b0 || imem_req_o !== 1'b0) begin n_fail++; $display("FAIL co_c6: v %b req %b want 0/0", v_o, imem_req_o); end
        @(negedge clk); #1; // c7
        n_tests++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h400 || busy_o !== 1'b0 || v_o !== 1'b0) begin n_fail++; $display("FAIL co_c7: req %b addr %h busy %b v %b want 1/400/0/0", imem_req_o, imem_addr_o, busy_o, v_o); end
        @(negedge clk); #1; // c8
        n_tests++; if (v_o !== 1'b0) begin n_fail++; $display("FAIL co_c8_v: got %b want 0", v_o); end
        for (int k = 9; k <= 12; k++) begin
            @(negedge clk); #1;
            n_tests++; if (v_o !== 1'b1 || pc_o !== 32'h400 + 32'(4*(k-9)) || inst_o !== 32'h1000_0400 + 32'(4*(k-9))) begin n_fail++; $display("FAIL co_c%0d: v %b pc %h inst %h want 1/%h", k, v_o, pc_o, inst_o, 32'h400 + 32'(4*(k-9))); end
        end
    endtask

    task automatic test_gnt_low;
        do_reset(1'b0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk); #1;
            n_tests++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL gnt_hold_c%0d: req %b addr %h want 1/0", k, imem_req_o, imem_addr_o); end
        end
        n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL gnt_busy: got %b want 0", busy_o); end
        @(negedge clk); imem_gnt_i = 1'b1; #1; // c4
        n_tests++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL gnt_c4: req %b addr %h want 1/0", imem_req_o, imem_addr_o); end
        @(negedge clk); #1; // c5
        n_tests++; if (imem_addr_o !== 32'h4) begin n_fail++; $display("FAIL gnt_c5_addr: got %h want 4", imem_addr_o); end
        @(negedge clk); #1; // c6
        n_tests++; if (v_o !== 1'b1 || pc_o !== 32'h0 || inst_o !== 32'h1000_0000) begin n_fail++; $display("FAIL gnt_c6: v %b pc %h inst %h want 1/0/10000000", v_o, pc_o, inst_o); end
    endtask

    task automatic test_halt;
        do_reset(1'b1);
        repeat (2) @(negedge clk);
        @(negedge clk); halt_i = 1'b1; #1; // c3
        n_tests++; if (imem_req_o !== 1'b0 || v_o !== 1'b1 || pc_o !== 32'h0) begin n_fail++; $display("FAIL halt_c3: req %b v %b pc %h want 0/1/0", imem_req_o, v_o, pc_o); end
        @(negedge clk); #1; // c4
        n_tests++; if (imem_req_o !== 1'b0 || v_o !== 1'b1 || pc_o !== 32'h4 || busy_o !== 1'b1) begin n_fail++; $display("FAIL halt_c4: req %b v %b pc %h busy %b want 0/1/4/1", imem_req_o, v_o, pc_o, busy_o); end
        @(negedge clk); #1; // c5
        n_tests++; if (imem_req_o !== 1'b0 || v_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL halt_c5: req %b v %b busy %b want 0/0/0", imem_req_o, v_o, busy_o); end
        @(negedge clk); halt_i = 1'b0; #1; // c6
        n_tests++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8) begin n_fail++; $display("FAIL halt_resume: req %b addr %h want 1/8", imem_req_o, imem_addr_o); end
        repeat (2) @(negedge clk); #1; // c8
        n_tests++; if (v_o !== 1'b1 || pc_o !== 32'h8) begin n_fail++; $display("FAIL halt_c8: v %b pc %h want 1/8", v_o, pc_o); end
    endtask

    task automatic test_reset_in_flush;
        do_reset(1'b1);
        @(negedge clk); mem_hold = 1'b1;
        @(negedge clk);
        @(negedge clk); branch_i = 1'b1; branch_pc_i = 32'h200;
        @(negedge clk); branch_i = 1'b0; #1; // c4, flushing
        n_tests++; if (busy_o !== 1'b1 || imem_addr_o !== 32'h200) begin n_fail++; $display("FAIL rf_pre: busy %b addr %h want 1/200", busy_o, imem_addr_o); end
        reset = 1'b1; branch_i = 1'b1; #1;
        n_tests++; if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h0 || flush_o !== 1'b0) begin n_fail++; $display("FAIL rf_req_addr_flush: req %b addr %h flush %b want 0/0/0", imem_req_o, imem_addr_o, flush_o); end
        n_tests++; if (v_o !== 1'b0 || inst_o !== 32'h0 || pc_o !== 32'h0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL rf_outputs: v %b inst %h pc %h busy %b want 0/0/0/0", v_o, inst_o, pc_o, busy_o); end
        @(negedge clk); branch_i = 1'b0; mem_hold = 1'b0;
        @(negedge clk); reset = 1'b0;
        @(negedge clk); #1; // c1 after release
        n_tests++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL rf_restart: req %b addr %h want 1/0", imem_req_o, imem_addr_o); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_stream();
        test_stall();
        test_branch_outstanding();
        test_branch_coincident();
        test_gnt_low();
        test_halt();
        test_reset_in_flush();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Front-end controller that drives the instruction fetch stage. It owns the program counter and issues word requests to instruction memory under a credit limit. It buffers returned words and delivers them with their PC to the downstream 2-entry instruction queue through its v/stall interface. On a branch it redirects the PC, discards stale in-flight data and flushes the queue.

Parameters:
ADDR, 32, PC/address width in bits (byte address)
WORD, 32, instruction width in bits
RESET_PC, 0, PC value loaded at reset
CREDITS, 2, max outstanding requests plus buffered words (2 or 4 only)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
imem_req_o  out  1  fetch request valid
imem_addr_o  out  ADDR  fetch address (current PC)
imem_gnt_i  in  1  request accepted this cycle (imem_req_o & imem_gnt_i = issue)
imem_rvalid_i  in  1  response valid; responses return in order
imem_rdata_i  in  WORD  response instruction
v_o  out  1  instruction valid to queue
inst_o  out  WORD  instruction to queue
pc_o  out  ADDR  PC of inst_o
stall_i  in  1  queue cannot accept (queue's stall_o)
branch_i  in  1  redirect request (one-cycle pulse)
branch_pc_i  in  ADDR  redirect target
flush_o  out  1  flush to queue (drives queue's branch_i)
halt_i  in  1  stop issuing new requests (level)
busy_o  out  1  outstanding requests or buffered words exist

Behaviour:
- Reset: pc=RESET_PC, state=IDLE, outstanding=0, drop=0, buffer empty. Outputs: imem_req_o=0, imem_addr_o=RESET_PC, v_o=0, inst_o=0, pc_o=0, flush_o=0, busy_o=0. Reset asserted mid-operation discards everything immediately.
- States: IDLE -> RUN one cycle after reset deasserts. RUN -> FLUSH on branch_i when in-flight responses (after this cycle's issue) > 0. FLUSH -> RUN when drop reaches 0.
- Issue (RUN only): imem_req_o = ~halt_i & ~branch_i & (outstanding + buf_count < CREDITS). imem_addr_o = pc.
- On issue: pc += 4 (wraps modulo 2^ADDR). Push pc onto an internal pc-tag FIFO (depth CREDITS). outstanding++.
- Request hold: imem_req_o must stay high with a stable address until granted, unless branch_i arrives.
- Response: imem_rvalid_i with drop>0 discards the response and decrements drop. Otherwise {tag pc, rdata} is written to the response buffer (depth CREDITS), the tag is popped and outstanding is decremented.
- rvalid with outstanding=0 is a protocol error. Assertion only; the response is ignored.
- Delivery: v_o = buffer non-empty. inst_o/pc_o = buffer head. The head pops when v_o & ~stall_i.
- Minimum latency: issue at cycle N, rvalid at N+1, v_o at N+2.
- Branch (any state except IDLE):
  - flush_o = branch_i, combinational.
  - pc <= branch_pc_i.
  - Buffer and tag FIFO cleared.
  - drop <= outstanding, plus 1 if an issue completes this same cycle, minus 1 if an rvalid arrives this same cycle. That response is dropped.
  - v_o = 0 from the next cycle.
- Branch during FLUSH: pc is retargeted, drop is unchanged, and the block stays in FLUSH.
- FLUSH: no issue. After the last drop, RUN issues from the new pc in the next cycle.
- busy_o = (outstanding | drop | buf_count) != 0.
- Counter widths: clog2(CREDITS)+1 bits. outstanding + buf_count never exceeds CREDITS.

Decomposition:
- Shared package / params include: ADDR, WORD, RESET_PC, the 4-byte PC increment constant, and state encodings IDLE/RUN/FLUSH.
- One sub-module, fetch_resp_buffer: a parameterised-depth FIFO of {pc, inst} with push, pop, clear, count and empty. It is used for the response buffer and, with inst unused, for the pc-tag FIFO.

Test Plan:
- Reset release, imem_gnt_i=1, 1-cycle memory returning 0x1000_0000+addr, stall_i=0 -> addresses 0,4,8,… on consecutive cycles, first v_o two cycles after first grant, pc_o/inst_o pairs (0,0x1000_0000),(4,0x1000_0004).
- stall_i=1 held from cycle 5 -> at most CREDITS words buffered, imem_req_o drops, no word lost or duplicated; releasing stall resumes in-order delivery.
- branch_i with branch_pc_i=0x200 while 2 requests outstanding -> flush_o pulse same cycle, FLUSH state, both responses dropped, next issued address 0x200, first delivered pc_o=0x200.
- branch_i coincident with a grant and an rvalid -> the granted request and the arriving response are both dropped; no pc_o other than the branch target appears.
- imem_gnt_i low for 3 cycles -> imem_req_o and imem_addr_o held stable; pc advances only on grant.
- halt_i=1 mid-stream -> no new issue, outstanding words still delivered, busy_o falls to 0; reset asserted during FLUSH -> all outputs at reset values immediately.
